// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode map, checker FSM states and the golden reference function.
package alu_pkg;

  localparam int unsigned ALU_MAX_W = 16;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned ERR_W     = 4;

  typedef enum logic [SEL_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Returns {cout, result}; cout sits at bit ALU_MAX_W, result in the low `width` bits.
  function automatic logic [ALU_MAX_W:0] alu_ref(
    input logic [ALU_MAX_W-1:0] a,
    input logic [ALU_MAX_W-1:0] b,
    input logic                 cin,
    input alu_op_t              op,
    input int unsigned          width
  );
    logic [ALU_MAX_W:0]   wide;
    logic [ALU_MAX_W-1:0] mask;
    logic                 co;
    wide = '0;
    co   = 1'b0;
    mask = ALU_MAX_W'((32'd1 << width) - 32'd1);
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b} + (ALU_MAX_W+1)'(cin);
        co   = wide[5'(width)];
      end
      OP_SUB: begin
        wide = {1'b0, a} - {1'b0, b};
        co   = (a < b);
      end
      OP_AND: wide = {1'b0, a & b};
      OP_OR:  wide = {1'b0, a | b};
      OP_XOR: wide = {1'b0, a ^ b};
      OP_NOT: wide = {1'b0, ~a};
      OP_SHL: begin
        wide = {a, 1'b0};
        co   = a[4'(width - 1)];
      end
      OP_SHR: begin
        wide = {1'b0, a >> 1};
        co   = a[0];
      end
      default: wide = '0;
    endcase
    return {co, wide[ALU_MAX_W-1:0] & mask};
  endfunction

endpackage

// File: rtl/alu_sweep_checker_if.sv
// Pin bundle between the sweep checker, its host (start/operands/status) and the ALU under test.
interface alu_sweep_checker_if #(
  parameter int unsigned WIDTH = 4
);
  import alu_pkg::*;

  logic                 start;
  logic [WIDTH-1:0]     a_in;
  logic [WIDTH-1:0]     b_in;
  logic                 cin_in;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 cin;
  logic [SEL_W-1:0]     sel;
  logic [WIDTH-1:0]     result;
  logic                 cout;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [ERR_W-1:0]     err_count;
  logic [SEL_W-1:0]     first_err_sel;

  modport master (
    output start, a_in, b_in, cin_in, result, cout,
    input  a, b, cin, sel, busy, done, pass, err_count, first_err_sel
  );

  modport slave (
    input  start, a_in, b_in, cin_in, result, cout,
    output a, b, cin, sel, busy, done, pass, err_count, first_err_sel
  );

endinterface

// File: rtl/alu_sweep_checker.sv
// Drives one latched operand set through all eight ALU opcodes and scores each sampled
// {cout,result} against alu_ref, reporting pass, mismatch count and first failing opcode.
module alu_sweep_checker
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DWELL = 2
) (
  input logic               clk,
  input logic               rst_n,
  alu_sweep_checker_if.slave bus
);

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               cin_q;
  logic [SEL_W-1:0]   sel_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic [ERR_W-1:0]   err_q;
  logic [SEL_W-1:0]   first_q;

  logic [ALU_MAX_W:0] expected_c;
  logic               mismatch_c;
  logic [ERR_W-1:0]   err_next_c;

  // Golden value for the opcode currently held on the ALU pins.
  assign expected_c = alu_ref(ALU_MAX_W'(a_q), ALU_MAX_W'(b_q), cin_q, alu_op_t'(sel_q), WIDTH);
  assign mismatch_c = {bus.cout, bus.result} != {expected_c[ALU_MAX_W], expected_c[WIDTH-1:0]};
  assign err_next_c = err_q + ERR_W'(mismatch_c);

  generate
    if (WIDTH < ALU_MAX_W) begin : g_ref_hi
      logic unused_ref_hi;
      assign unused_ref_hi = ^expected_c[ALU_MAX_W-1:WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sel_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a_in;
            b_q     <= bus.b_in;
            cin_q   <= bus.cin_in;
            err_q   <= '0;
            pass_q  <= 1'b0;
            first_q <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == CNT_W'(DWELL - 1)) begin
            state_q <= ST_CHECK;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_CHECK: begin
          err_q <= err_next_c;
          if (mismatch_c && (err_q == '0)) begin
            first_q <= sel_q;
          end
          // pass/done become visible together during the DONE cycle.
          if (sel_q == SEL_W'(7)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_next_c == '0);
            state_q <= ST_DONE;
          end else begin
            sel_q   <= sel_q + SEL_W'(1);
            cnt_q   <= '0;
            state_q <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          sel_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.a             = a_q;
  assign bus.b             = b_q;
  assign bus.cin           = cin_q;
  assign bus.sel           = sel_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_count     = err_q;
  assign bus.first_err_sel = first_q;

endmodule

// File: tb/tb_alu_sweep_checker.sv
// Bench for alu_sweep_checker: behavioural ALU (with fault injection) on the pins, table
// vectors, hand-written timing corners and randomized sweeps scored by fault bookkeeping.
module tb_alu_sweep_checker;

  localparam int unsigned W = 4;
  localparam int M = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_sweep_checker_if #(.WIDTH(W)) bus2 ();
  alu_sweep_checker_if #(.WIDTH(W)) bus1 ();

  alu_sweep_checker #(.WIDTH(W), .DWELL(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  alu_sweep_checker #(.WIDTH(W), .DWELL(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int checks = 0;
  int failures = 0;

  // ALU behaviour controls: 0 = arithmetic model, 1 = table lookup of cur_ops.
  int              alu_mode = 0;
  logic [7:0][4:0] cur_ops;
  logic [7:0]      fault_mask;
  logic [7:0][4:0] fault_xor;
  logic            spec_fault;
  logic [4:0]      alu2_v;

  typedef struct packed {
    logic [3:0]      a;
    logic [3:0]      b;
    logic            cin;
    logic [7:0][4:0] ops;
    logic [7:0]      fmask;
    logic [3:0]      exp_err;
    logic [2:0]      exp_first;
    logic            exp_pass;
  } vec_t;

  vec_t vecs[6];

  // Plain-arithmetic opcode semantics, returns {cout,result}.
  function automatic logic [4:0] ref_op(input int a, input int b, input int c, input int op);
    int r;
    int co;
    r  = 0;
    co = 0;
    case (op)
      0: begin r = a + b + c; co = r / M; r = r % M; end
      1: begin co = (a < b) ? 1 : 0; r = (a - b + M) % M; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = M - 1 - a;
      6: begin r = (a * 2) % M; co = a / (M / 2); end
      7: begin r = a / 2; co = a % 2; end
      default: r = 0;
    endcase
    return {co[0], r[3:0]};
  endfunction

  always_comb begin
    alu2_v = ref_op(int'(bus2.a), int'(bus2.b), int'(bus2.cin), int'(bus2.sel));
    if (alu_mode == 1) alu2_v = cur_ops[bus2.sel];
    if (spec_fault && bus2.sel == 3'd3) alu2_v = {alu2_v[4], 4'b0000};
    if (spec_fault && bus2.sel == 3'd7) alu2_v = {alu2_v[4], 4'b1111};
    if (fault_mask[bus2.sel]) alu2_v = alu2_v ^ fault_xor[bus2.sel];
  end
  assign bus2.cout   = alu2_v[4];
  assign bus2.result = alu2_v[3:0];

  logic [4:0] alu1_v;
  always_comb alu1_v = ref_op(int'(bus1.a), int'(bus1.b), int'(bus1.cin), int'(bus1.sel));
  assign bus1.cout   = alu1_v[4];
  assign bus1.result = alu1_v[3:0];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset2(input string tag);
    check({tag, " a"}, int'(bus2.a), 0);
    check({tag, " b"}, int'(bus2.b), 0);
    check({tag, " cin"}, int'(bus2.cin), 0);
    check({tag, " sel"}, int'(bus2.sel), 0);
    check({tag, " busy"}, int'(bus2.busy), 0);
    check({tag, " done"}, int'(bus2.done), 0);
    check({tag, " pass"}, int'(bus2.pass), 0);
    check({tag, " err"}, int'(bus2.err_count), 0);
    check({tag, " first"}, int'(bus2.first_err_sel), 0);
  endtask

  // One DWELL=2 sweep; optional second start pulse at cycle `poke` with other operands.
  task automatic sweep2(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic c, input int poke, input int exp_err,
                        input int exp_first, input int exp_pass);
    int lat;
    @(negedge clk);
    bus2.a_in = a; bus2.b_in = b; bus2.cin_in = c; bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0; bus2.a_in = ~a; bus2.b_in = ~b; bus2.cin_in = ~c;
    lat = 1;
    check({tag, " busy_t1"}, int'(bus2.busy), 1);
    check({tag, " sel_t1"}, int'(bus2.sel), 0);
    while (bus2.done !== 1'b1 && lat < 200) begin
      bus2.start = (lat == poke);
      @(negedge clk);
      lat++;
    end
    bus2.start = 1'b0;
    check({tag, " latency"}, lat, 25);
    check({tag, " busy_in_done"}, int'(bus2.busy), 0);
    check({tag, " pass"}, int'(bus2.pass), exp_pass);
    check({tag, " err_count"}, int'(bus2.err_count), exp_err);
    if (exp_err != 0) check({tag, " first_err_sel"}, int'(bus2.first_err_sel), exp_first);
    @(negedge clk);
    check({tag, " done_one_cycle"}, int'(bus2.done), 0);
    check({tag, " pass_held"}, int'(bus2.pass), exp_pass);
    check({tag, " a_held"}, int'(bus2.a), int'(a));
    check({tag, " b_held"}, int'(bus2.b), int'(b));
    check({tag, " cin_held"}, int'(bus2.cin), int'(c));
  endtask

  function automatic vec_t mkvec(input logic [3:0] a, input logic [3:0] b, input logic c,
                                 input logic [7:0][4:0] ops, input logic [7:0] fm,
                                 input logic [3:0] ee, input logic [2:0] ef, input logic ep);
    vec_t v;
    v.a = a; v.b = b; v.cin = c; v.ops = ops; v.fmask = fm;
    v.exp_err = ee; v.exp_first = ef; v.exp_pass = ep;
    return v;
  endfunction

  initial begin
    logic [7:0][4:0] ops0, ops1, ops2, ops3;
    logic [3:0] ra, rb;
    logic rc;
    int ee, ef, lat;
    int dq[$];
    logic bh[64];

    // ops listed from opcode 111 down to 000
    ops0 = {5'b0_0101, 5'b1_0100, 5'b0_0101, 5'b0_1111, 5'b0_1111, 5'b0_0000, 5'b0_0101, 5'b0_1111};
    ops1 = {5'b1_0111, 5'b1_1110, 5'b0_0000, 5'b0_1110, 5'b0_1111, 5'b0_0001, 5'b0_1110, 5'b1_0001};
    ops2 = {5'b1_0001, 5'b0_0110, 5'b0_1100, 5'b0_0110, 5'b0_0111, 5'b0_0001, 5'b1_1110, 5'b0_1001};
    ops3 = {5'b0_0000, 5'b0_0000, 5'b0_1111, 5'b0_0000, 5'b0_0000, 5'b0_0000, 5'b0_0000, 5'b0_0001};
    vecs[0] = mkvec(4'b1010, 4'b0101, 1'b0, ops0, 8'h00, 4'd0, 3'd0, 1'b1);
    vecs[1] = mkvec(4'b1111, 4'b0001, 1'b1, ops1, 8'h00, 4'd0, 3'd0, 1'b1);
    vecs[2] = mkvec(4'b0011, 4'b0101, 1'b1, ops2, 8'h00, 4'd0, 3'd0, 1'b1);
    vecs[3] = mkvec(4'b0000, 4'b0000, 1'b1, ops3, 8'h00, 4'd0, 3'd0, 1'b1);
    vecs[4] = mkvec(4'b1010, 4'b0101, 1'b0, ops0, 8'b1000_0001, 4'd2, 3'd0, 1'b0);
    vecs[5] = mkvec(4'b0011, 4'b0101, 1'b1, ops2, 8'b0110_0000, 4'd2, 3'd5, 1'b0);

    bus2.start = 1'b0; bus2.a_in = '0; bus2.b_in = '0; bus2.cin_in = 1'b0;
    bus1.start = 1'b0; bus1.a_in = '0; bus1.b_in = '0; bus1.cin_in = 1'b0;
    cur_ops = '0; fault_mask = '0; fault_xor = '0; spec_fault = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset2("reset");
    check("reset dut1 busy", int'(bus1.busy), 0);
    check("reset dut1 done", int'(bus1.done), 0);
    rst_n = 1'b1;

    // Table vectors: ALU replays the expected per-opcode values, with optional corruption.
    alu_mode = 1;
    for (int i = 0; i < 6; i++) begin
      cur_ops = vecs[i].ops;
      fault_mask = vecs[i].fmask;
      for (int k = 0; k < 8; k++) fault_xor[k] = 5'b00001;
      sweep2($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, -1,
             int'(vecs[i].exp_err), int'(vecs[i].exp_first), int'(vecs[i].exp_pass));
    end
    alu_mode = 0;
    fault_mask = '0;

    // Faulty ALU: OR stuck at 0000, SHR stuck at 1111.
    spec_fault = 1'b1;
    sweep2("spec_fault", 4'b1010, 4'b0101, 1'b0, -1, 2, 3, 0);
    spec_fault = 1'b0;

    // Second start during the sweep is ignored.
    sweep2("restart_ignored", 4'b0110, 4'b1001, 1'b1, 5, 0, 0, 1);

    // Reset mid-sweep with a fault already counted.
    fault_mask = 8'b0000_0010;
    fault_xor[1] = 5'b00001;
    @(negedge clk);
    bus2.a_in = 4'b1100; bus2.b_in = 4'b0011; bus2.cin_in = 1'b1; bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    lat = 1;
    while (lat < 10) begin @(negedge clk); lat++; end
    check("pre_reset busy", int'(bus2.busy), 1);
    check("pre_reset err", int'(bus2.err_count), 1);
    rst_n = 1'b0;
    #1;
    check_reset2("mid_reset");
    repeat (3) begin
      @(negedge clk);
      check("mid_reset no done", int'(bus2.done), 0);
    end
    rst_n = 1'b1;
    fault_mask = '0;
    sweep2("post_reset", 4'b1100, 4'b0011, 1'b1, -1, 0, 0, 1);

    // DWELL=1, start held: done every 18 cycles, first at 17.
    @(negedge clk);
    bus1.a_in = 4'b1001; bus1.b_in = 4'b0111; bus1.cin_in = 1'b1; bus1.start = 1'b1;
    for (int cyc = 1; cyc < 61; cyc++) begin
      @(negedge clk);
      if (cyc < 64) bh[cyc] = bus1.busy;
      if (bus1.done === 1'b1) begin
        dq.push_back(cyc);
        check("b2b pass", int'(bus1.pass), 1);
        check("b2b err", int'(bus1.err_count), 0);
      end
    end
    bus1.start = 1'b0;
    check("b2b done count", dq.size(), 3);
    if (dq.size() >= 3) begin
      check("b2b first done", dq[0], 17);
      check("b2b second done", dq[1], 35);
      check("b2b third done", dq[2], 53);
    end
    check("b2b busy c1", int'(bh[1]), 1);
    check("b2b busy in done", int'(bh[17]), 0);
    check("b2b busy idle", int'(bh[18]), 0);
    check("b2b busy restart", int'(bh[19]), 1);

    // Randomized operands and fault patterns.
    for (int n = 0; n < 20; n++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      fault_mask = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      for (int k = 0; k < 8; k++) fault_xor[k] = 5'($urandom_range(1, 31));
      ee = $countones(fault_mask);
      ef = 0;
      for (int k = 7; k >= 0; k--) if (fault_mask[k]) ef = k;
      sweep2($sformatf("rand%0d", n), ra, rb, rc, -1, ee, ef, (ee == 0) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sweep_checker.md
# alu_sweep_checker

Self-checking ALU exerciser. On `start` it latches one operand set, drives the ALU through all eight opcodes, and samples `result`/`cout` after a settle window. It compares each sample against an internal reference model and reports pass/fail, an error count and the first failing opcode. It sits on the ALU's input/output pins in place of a simulation-only stimulus process, so the same sweep runs in silicon or on FPGA.

## Interface
- `WIDTH`, 4: operand/result width.
- `DWELL`, 2: cycles each opcode is held before sampling. Range is 1..15.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a sweep. Accepted only in IDLE.
- `a_in`, `b_in` in WIDTH: operands, latched on the accepted `start`.
- `cin_in` in 1: carry-in, latched on the accepted `start`.
- `a`, `b` out WIDTH: operands driven to the ALU.
- `cin` out 1: carry-in driven to the ALU.
- `sel` out 3: opcode driven to the ALU.
- `result` in WIDTH: ALU result.
- `cout` in 1: ALU carry/flag output.
- `busy` out 1: high while a sweep is in progress.
- `done` out 1: one-cycle pulse when a sweep ends.
- `pass` out 1: 1 when the last sweep had zero mismatches. Held until the next accepted `start`.
- `err_count` out 4: number of mismatching opcodes in the last sweep, 0..8.
- `first_err_sel` out 3: opcode of the first mismatch. Valid when `err_count != 0`.

## Operation
- Opcode map (reference model), with `cout` value:
  - 000: `a+b+cin`; `cout` = carry out of the MSB.
  - 001: `a-b`; `cout` = 1 when a<b (borrow).
  - 010: `a&b`; `cout` = 0.
  - 011: `a|b`; `cout` = 0.
  - 100: `a^b`; `cout` = 0.
  - 101: `~a`; `cout` = 0.
  - 110: `a<<1`; `cout` = a[MSB].
  - 111: `a>>1`; `cout` = a[0].
  - `cin` is ignored for every op except 000.
- Arithmetic is computed at WIDTH+1 bits. The low WIDTH bits give the result; bit WIDTH gives carry/borrow.
- FSM states are IDLE, DRIVE, CHECK, DONE.
- IDLE:
  - `start`=1 → latch operands, clear `err_count`/`pass`/`first_err_sel`, set `sel`=0 and dwell counter=0, go to DRIVE.
- DRIVE:
  - Hold `sel`; increment the dwell counter.
  - When the counter reaches DWELL-1, go to CHECK.
- CHECK (one cycle):
  - Compare `{cout,result}` against the model for the current `sel`.
  - On mismatch, increment `err_count`. If `err_count` was 0, load `first_err_sel`.
  - If `sel`==7, go to DONE. Otherwise increment `sel`, clear the counter and go to DRIVE.
- DONE (one cycle):
  - `done`=1; `pass` is set to (`err_count`==0).
  - Return to IDLE. `sel` returns to 0.
- `a`, `b`, `cin` hold the latched operands in every state, including after the sweep, until the next accepted `start`.
- `start` while `busy` is ignored. `start` during the DONE cycle is ignored; it is only accepted in IDLE.
- `err_count` saturation is never needed, since the maximum is 8 and it fits in 4 bits.

## Timing
- Reset values: `a`=0, `b`=0, `cin`=0, `sel`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_sel`=0; state IDLE.
- Reset asserted mid-sweep aborts immediately to the reset values. No `done` is produced.
- `start` is sampled at edge T0. At T0+1, `busy`=1 and `sel`=0.
- Each opcode occupies DWELL cycles in DRIVE plus 1 cycle in CHECK. The ALU therefore has at least DWELL cycles of settle time before sampling.
- In CHECK, `result`/`cout` are sampled at the edge that ends the CHECK cycle.
- Sweep length is 8·(DWELL+1) cycles with `busy`=1, followed by 1 DONE cycle.
  - `done` is high during the DONE cycle.
  - `busy` is low during DONE.
- Earliest next accepted `start` is the cycle after DONE.
- Total latency from `start` to `done`, with DWELL=2, is 25 cycles.

## Structure
- Package `alu_pkg` holds:
  - an `alu_op_t` enum for the eight opcodes (ADD, SUB, AND, OR, XOR, NOT, SHL, SHR);
  - the FSM state enum;
  - the function `alu_ref(a,b,cin,op)` returning `{cout,result}`.
- The same package is to be imported by the ALU itself and by benches.
- A sub-module is not needed. The reference model is the package function, and the FSM with its counters lives in `alu_sweep_checker`.

## Test plan
- Good ALU, a=1010, b=0101, cin=0, DWELL=2 → per-op expected `{cout,result}`:
  - 000: 0_1111; 001: 0_0101; 010: 0_0000; 011: 0_1111
  - 100: 0_1111; 101: 0_0101; 110: 1_0100; 111: 0_0101
  - `done` 25 cycles after `start`; `pass`=1, `err_count`=0.
- Good ALU, a=1111, b=0001, cin=1 → ADD result 0001 with `cout`=1; SUB result 1110 with `cout`=0; `pass`=1.
- Faulty ALU model: OR (011) returns 0000 and SHR (111) returns 1111 → `err_count`=2, `first_err_sel`=011, `pass`=0.
- `start` pulsed again at cycle 5 of a sweep with different operands → ignored. `a`/`b` unchanged and the sweep length is still 25 cycles.
- `rst_n` dropped at cycle 10 of a sweep → all outputs at reset values in the same cycle, no `done`. A new sweep after release completes normally.
- DWELL=1 with back-to-back sweeps (`start` held high) → sweeps of 17 cycles each, the second beginning the cycle after DONE, `done` pulsing once per sweep.
